// File: rtl/yd_regfile_param.sv
// Parametrised Yduck register file: ZE/DK/GPR/PC map, two write ports, NRP registered read ports
// with write-through bypass and read hold. Optional macro YD_RF_SHADOW_EN adds a banked GPR set.
module yd_regfile_param #(
    parameter int          DW     = 16,
    parameter int          AW     = 4,
    parameter int          NRP    = 2,
    parameter logic [DW-1:0] PC_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jpc,
    input  logic              dsv,
    input  logic              hold,
`ifdef YD_RF_SHADOW_EN
    input  logic              bank_sw,
`endif
    input  logic              we0,
    input  logic [AW-1:0]     waddr0,
    input  logic [DW-1:0]     din0,
    input  logic              we1,
    input  logic [AW-1:0]     waddr1,
    input  logic [DW-1:0]     din1,
    input  logic [NRP*AW-1:0] raddr,
    output logic [NRP*DW-1:0] dout,
    output logic [DW-1:0]     pc,
    output logic [DW-1:0]     dkd
);

    localparam int            NREG = 2**AW;
    localparam logic [AW-1:0] DK_A = AW'(1);
    localparam logic [AW-1:0] PC_A = AW'(NREG-1);

    logic [DW-1:0] pc_reg;
    logic [DW-1:0] dk_reg;
    logic [DW-1:0] regs_rd [NREG];

    logic          pc_wr0;
    logic          pc_wr1;

    logic [NRP*AW-1:0] raddr_reg;
    logic              we0_reg;
    logic              we1_reg;
    logic [AW-1:0]     waddr0_reg;
    logic [AW-1:0]     waddr1_reg;
    logic [DW-1:0]     din0_reg;
    logic [DW-1:0]     din1_reg;
    logic              jpc_reg;

`ifdef YD_RF_SHADOW_EN
    logic bank_reg;
    logic wbank_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_reg <= 1'b0;
        end else if (bank_sw) begin
            bank_reg <= ~bank_reg;
        end
    end
`endif

    // DK forwarding doubles as the DK register's next value
    assign dkd = (we0 && (waddr0 == DK_A)) ? din0 :
                 (we1 && (waddr1 == DK_A)) ? din1 : dk_reg;

    assign pc_wr0 = we0 && (waddr0 == PC_A) && jpc;
    assign pc_wr1 = we1 && (waddr1 == PC_A) && jpc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dk_reg <= '0;
        end else begin
            dk_reg <= dkd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= PC_RST;
        end else if (pc_wr0) begin
            pc_reg <= din0;
        end else if (pc_wr1) begin
            pc_reg <= din1;
        end else if (!jpc && !dsv) begin
            pc_reg <= pc_reg + DW'(1);
        end
    end

    assign pc = pc_reg;

    assign regs_rd[0]      = '0;
    assign regs_rd[1]      = dk_reg;
    assign regs_rd[NREG-1] = pc_reg;

    genvar gi;
    generate
        for (gi = 2; gi < NREG-1; gi++) begin : g_gpr
            logic          wr0;
            logic          wr1;
            logic [DW-1:0] wdata;

            assign wr0   = we0 && (waddr0 == AW'(gi));
            assign wr1   = we1 && (waddr1 == AW'(gi));
            assign wdata = wr0 ? din0 : din1;
`ifdef YD_RF_SHADOW_EN
            logic [DW-1:0] b0_reg;
            logic [DW-1:0] b1_reg;

            // A write in the toggle cycle still uses bank_reg, i.e. the old bank
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    b0_reg <= '0;
                    b1_reg <= '0;
                end else if (wr0 || wr1) begin
                    if (bank_reg) begin
                        b1_reg <= wdata;
                    end else begin
                        b0_reg <= wdata;
                    end
                end
            end

            assign regs_rd[gi] = bank_reg ? b1_reg : b0_reg;
`else
            logic [DW-1:0] r_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_reg <= '0;
                end else if (wr0 || wr1) begin
                    r_reg <= wdata;
                end
            end

            assign regs_rd[gi] = r_reg;
`endif
        end
    endgenerate

    // Read-address and bypass pipe; frozen as a whole while hold is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr_reg  <= '0;
            we0_reg    <= 1'b0;
            we1_reg    <= 1'b0;
            waddr0_reg <= '0;
            waddr1_reg <= '0;
            din0_reg   <= '0;
            din1_reg   <= '0;
            jpc_reg    <= 1'b0;
`ifdef YD_RF_SHADOW_EN
            wbank_reg  <= 1'b0;
`endif
        end else if (!hold) begin
            raddr_reg  <= raddr;
            we0_reg    <= we0;
            we1_reg    <= we1;
            waddr0_reg <= waddr0;
            waddr1_reg <= waddr1;
            din0_reg   <= din0;
            din1_reg   <= din1;
            jpc_reg    <= jpc;
`ifdef YD_RF_SHADOW_EN
            wbank_reg  <= bank_reg;
`endif
        end
    end

    generate
        for (gi = 0; gi < NRP; gi++) begin : g_rport
            logic [AW-1:0] ra;
            logic          addr_ok;
            logic          hit0;
            logic          hit1;
            logic [DW-1:0] rd;

            assign ra = raddr_reg[gi*AW +: AW];
`ifdef YD_RF_SHADOW_EN
            // A bypassed GPR write only counts if it went into the bank now being read
            assign addr_ok = ((ra == PC_A) ? jpc_reg : 1'b1) &&
                             ((ra == DK_A) || (ra == PC_A) || (wbank_reg == bank_reg));
`else
            assign addr_ok = (ra == PC_A) ? jpc_reg : 1'b1;
`endif
            assign hit0 = we0_reg && (waddr0_reg == ra) && addr_ok;
            assign hit1 = we1_reg && (waddr1_reg == ra) && addr_ok;

            always_comb begin
                rd = regs_rd[ra];
                if (ra == '0) begin
                    rd = '0;
                end else if (hit0) begin
                    rd = din0_reg;
                end else if (hit1) begin
                    rd = din1_reg;
                end
            end

            assign dout[gi*DW +: DW] = rd;
        end
    endgenerate

endmodule

// File: tb/tb_yd_regfile_param.sv
// Self-checking bench for yd_regfile_param: vector table driven per cycle, expected read data
// and PC queued at drive time and compared after the clock edge.
module tb_yd_regfile_param;

    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int NRP = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              jpc;
    logic              dsv;
    logic              hold;
`ifdef YD_RF_SHADOW_EN
    logic              bank_sw;
`endif
    logic              we0;
    logic [AW-1:0]     waddr0;
    logic [DW-1:0]     din0;
    logic              we1;
    logic [AW-1:0]     waddr1;
    logic [DW-1:0]     din1;
    logic [NRP*AW-1:0] raddr;
    logic [NRP*DW-1:0] dout;
    logic [DW-1:0]     pc;
    logic [DW-1:0]     dkd;

    yd_regfile_param #(.DW(DW), .AW(AW), .NRP(NRP), .PC_RST(16'h0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .jpc    (jpc),
        .dsv    (dsv),
        .hold   (hold),
`ifdef YD_RF_SHADOW_EN
        .bank_sw(bank_sw),
`endif
        .we0    (we0),
        .waddr0 (waddr0),
        .din0   (din0),
        .we1    (we1),
        .waddr1 (waddr1),
        .din1   (din1),
        .raddr  (raddr),
        .dout   (dout),
        .pc     (pc),
        .dkd    (dkd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] d0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] d1;
        logic          jpc;
        logic          dsv;
        logic          hold;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] e_dkd;
        logic [DW-1:0] e_pc;
        logic [DW-1:0] e_d0;
        logic [DW-1:0] e_d1;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [DW-1:0] pc;
    } exp_t;

    vec_t vq[$];
    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(
        input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] x0,
        input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] x1,
        input logic j, input logic ds, input logic h,
        input logic [AW-1:0] r0, input logic [AW-1:0] r1,
        input logic [DW-1:0] edk, input logic [DW-1:0] epc,
        input logic [DW-1:0] ed0, input logic [DW-1:0] ed1);
        vec_t v;
        v.we0 = w0; v.wa0 = a0; v.d0 = x0;
        v.we1 = w1; v.wa1 = a1; v.d1 = x1;
        v.jpc = j;  v.dsv = ds; v.hold = h;
        v.ra0 = r0; v.ra1 = r1;
        v.e_dkd = edk; v.e_pc = epc; v.e_d0 = ed0; v.e_d1 = ed1;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        exp_t e;

        // we0 wa0 din0      we1 wa1 din1      jpc dsv hold ra0 ra1  dkd       pc        dout0     dout1
        vq.push_back(mk(1, 2, 16'h1234, 0, 0, 16'h0000, 0, 1, 0, 2, 0,  16'h0000, 16'h0000, 16'h1234, 16'h0000));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 2, 2,  16'h0000, 16'h0000, 16'h1234, 16'h1234));
        vq.push_back(mk(1, 5, 16'hAAAA, 1, 5, 16'h5555, 0, 1, 0, 5, 5,  16'h0000, 16'h0000, 16'hAAAA, 16'hAAAA));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 5, 5,  16'h0000, 16'h0000, 16'hAAAA, 16'hAAAA));
        vq.push_back(mk(1, 0, 16'hBEEF, 0, 0, 16'h0000, 0, 1, 0, 0, 2,  16'h0000, 16'h0000, 16'h0000, 16'h1234));
        vq.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0077, 0, 1, 0, 1, 0,  16'h0077, 16'h0000, 16'h0077, 16'h0000));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 1, 5,  16'h0077, 16'h0000, 16'h0077, 16'hAAAA));
        vq.push_back(mk(1, 1, 16'h1111, 1, 1, 16'h2222, 0, 1, 0, 1, 3,  16'h1111, 16'h0000, 16'h1111, 16'h0000));
        vq.push_back(mk(1, 3, 16'h0303, 1, 4, 16'h0404, 0, 1, 0, 3, 4,  16'h1111, 16'h0000, 16'h0303, 16'h0404));
        // PC: jump load, wrap, dsv stall, port-1 jump, dropped write, jpc stall
        vq.push_back(mk(1, 15, 16'hFFFF, 0, 0, 16'h0000, 1, 1, 0, 15, 0, 16'h1111, 16'hFFFF, 16'hFFFF, 16'h0000));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 15, 0,  16'h1111, 16'h0000, 16'h0000, 16'h0000));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 15, 0,  16'h1111, 16'h0000, 16'h0000, 16'h0000));
        vq.push_back(mk(0, 0, 16'h0000, 1, 15, 16'h0040, 1, 0, 0, 15, 0, 16'h1111, 16'h0040, 16'h0040, 16'h0000));
        vq.push_back(mk(0, 0, 16'h0000, 1, 15, 16'h1357, 0, 0, 0, 15, 0, 16'h1111, 16'h0041, 16'h0041, 16'h0000));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 15, 2,  16'h1111, 16'h0041, 16'h0041, 16'h1234));
        // hold: capture 3/4, freeze while address moves, release
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 3, 4,  16'h1111, 16'h0041, 16'h0303, 16'h0404));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 4, 3,  16'h1111, 16'h0041, 16'h0303, 16'h0404));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 4, 3,  16'h1111, 16'h0041, 16'h0303, 16'h0404));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 4, 3,  16'h1111, 16'h0041, 16'h0404, 16'h0303));
        // a write during hold still reaches the array and shows on a held address
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 6, 6,  16'h1111, 16'h0041, 16'h0000, 16'h0000));
        vq.push_back(mk(1, 6, 16'h6666, 0, 0, 16'h0000, 0, 1, 1, 2, 2,  16'h1111, 16'h0041, 16'h6666, 16'h6666));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 2, 6,  16'h1111, 16'h0041, 16'h1234, 16'h6666));

        rst = 1'b1; jpc = 1'b0; dsv = 1'b1; hold = 1'b0;
`ifdef YD_RF_SHADOW_EN
        bank_sw = 1'b0;
`endif
        we0 = 1'b0; waddr0 = '0; din0 = '0;
        we1 = 1'b0; waddr1 = '0; din1 = '0;
        raddr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_pc", pc, 16'h0000);
        chk("reset_dout0", dout[0 +: DW], 16'h0000);
        chk("reset_dout1", dout[DW +: DW], 16'h0000);
        chk("reset_dkd", dkd, 16'h0000);

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            @(negedge clk);
            we0 = v.we0; waddr0 = v.wa0; din0 = v.d0;
            we1 = v.we1; waddr1 = v.wa1; din1 = v.d1;
            jpc = v.jpc; dsv = v.dsv; hold = v.hold;
            raddr = {v.ra1, v.ra0};
            #1;
            chk($sformatf("v%0d_dkd", i), dkd, v.e_dkd);
            e.d0 = v.e_d0; e.d1 = v.e_d1; e.pc = v.e_pc;
            sbq.push_back(e);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            chk($sformatf("v%0d_dout0", i), dout[0 +: DW], e.d0);
            chk($sformatf("v%0d_dout1", i), dout[DW +: DW], e.d1);
            chk($sformatf("v%0d_pc", i), pc, e.pc);
            $display("vec %0d: dout0=%h dout1=%h pc=%h dkd=%h", i, dout[0 +: DW], dout[DW +: DW], pc, dkd);
        end

        // asynchronous reset mid-cycle, no clock edge in between
        @(negedge clk);
        we0 = 1'b0; we1 = 1'b0; hold = 1'b0; jpc = 1'b0; dsv = 1'b1;
        raddr = {4'd6, 4'd2};
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", pc, 16'h0000);
        chk("async_rst_dout0", dout[0 +: DW], 16'h0000);
        chk("async_rst_dout1", dout[DW +: DW], 16'h0000);
        chk("async_rst_dkd", dkd, 16'h0000);
        $display("async reset: pc=%h dout=%h dkd=%h", pc, dout, dkd);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_reg2", dout[0 +: DW], 16'h0000);
        chk("post_rst_reg6", dout[DW +: DW], 16'h0000);
        $display("post reset read: dout0=%h dout1=%h", dout[0 +: DW], dout[DW +: DW]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/yd_regfile_param.md
Name: yd_regfile_param

Overview:
- Parametrised next-generation register file for the Yduck core: configurable data width, register count and read-port count, with two write ports.
- Carries forward the fixed register map: address 0 is the hard-wired zero ZE, address 1 is DK, the top address is PC, and the rest are general-purpose.
- Adds registered reads with write-through bypass, a read-hold (pipeline freeze) input, and a correct direct DK output.
- Sits between the decode stage and the execute/memory units of the core.

Parameters:
DW, 16, data width of every register and port.
AW, 4, address width; register count is 2**AW; PC address is 2**AW-1.
NRP, 2, number of read ports (1..4).
PC_RST, 0, PC reset value (DW bits).

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
jpc  in  1  jump: enables writes to the PC address
dsv  in  1  data-bus access in progress; suppresses PC increment
hold  in  1  freeze read-address capture and read outputs
we0  in  1  write enable, port 0
waddr0  in  AW  write address, port 0
din0  in  DW  write data, port 0
we1  in  1  write enable, port 1
waddr1  in  AW  write address, port 1
din1  in  DW  write data, port 1
raddr  in  NRP*AW  packed read addresses; port k uses bits [k*AW +: AW]
dout  out  NRP*DW  packed read data; port k uses bits [k*DW +: DW]
pc  out  DW  current PC
dkd  out  DW  DK value with same-cycle write forwarding

Behaviour:
- Reset (async): all general-purpose registers and DK = 0; pc = PC_RST; dout = 0; internal address and bypass pipes = 0.
  - On release, the first rising edge behaves as a normal cycle.
- Writes take effect at posedge.
  - ZE writes are ignored.
  - PC-address writes are accepted only when jpc=1; otherwise they are dropped.
  - If both ports write the same address, port 0 wins. Otherwise both writes apply.
- PC update, in priority order:
  1. Accepted PC write → loads the written value.
  2. Else if jpc=0 and dsv=0 → pc+1, wrapping modulo 2**DW.
  3. Else pc holds.
  - jpc=1 with no PC write → pc holds.
- Read address capture:
  - When hold=0, raddr is registered at posedge; we0, we1, waddr0/1, din0/1 and jpc are registered alongside it.
  - When hold=1, all of these registers keep their previous values.
- Read data is combinational from the registered address (1-cycle latency from raddr to dout).
  - Registered address = 0 → dout = 0.
  - Registered address matches a registered write → dout = registered din of that write (port 0 first).
  - For the PC address, the bypass applies only if the registered jpc=1.
  - Otherwise dout = current register contents.
- hold=1 freezes dout only while register contents are unchanged; writes still update the array during hold.
- dkd is purely combinational:
  - we0 && waddr0==1 → din0;
  - else we1 && waddr1==1 → din1;
  - else DK.
  - dkd must never infer a latch.
- All read ports are independent and identical.

Optional Feature:
YD_RF_SHADOW_EN
- When defined:
  - Adds input bank_sw (1 bit) and a second bank of the general-purpose registers (ZE, DK and PC are not banked).
  - The active-bank bit toggles at posedge when bank_sw=1; it resets to 0.
  - Reads, writes and bypass address only the active bank.
  - A write in the toggle cycle lands in the old bank.
- When undefined: single bank, no bank_sw port, identical to the base behaviour.

Test Plan:
- Reset: assert rst mid-cycle → pc=PC_RST, dout=0, dkd=0 immediately, with no clock edge needed.
- Write then read (port 0): we0=1, waddr0=2, din0=16'h1234, raddr port0=2 in the same cycle → next cycle dout port0=16'h1234; cycle after that, with no write, still 16'h1234.
- Write conflict: we0/we1 both to address 5, din0=16'hAAAA, din1=16'h5555 → register 5 = 16'hAAAA; both read ports on address 5 read 16'hAAAA.
- PC: from pc=16'hFFFF with jpc=0, dsv=0 → 16'h0000; with dsv=1, pc holds; jpc=1, we1=1, waddr1=15, din1=16'h0040 → pc=16'h0040; the same write with jpc=0 → pc increments and the write is ignored.
- ZE and dkd: write 16'hBEEF to address 0 → reads 0; we1=1, waddr1=1, din1=16'h0077 → dkd=16'h0077 in the same cycle, and DK=16'h0077 after the edge.
- Hold: raddr=3 captured, then hold=1 while raddr changes to 4 → dout stays on register 3 for the whole hold; after release, register 4 appears one cycle later.
